wm_supervisor: RTL and testbench



---
 rtl/wm_pkg.sv | 33 +++
 rtl/wm_stage_checker.sv | 29 ++
 rtl/wm_supervisor.sv | 148 ++++++++++++++
 tb/tb_wm_supervisor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine stage interface and its supervisor.
package wm_pkg;

    // Stage encodings reported by the machine FSM.
    localparam logic [2:0] STG_IDLE  = 3'd0;
    localparam logic [2:0] STG_FILL  = 3'd1;
    localparam logic [2:0] STG_WASH  = 3'd2;
    localparam logic [2:0] STG_RINSE = 3'd3;
    localparam logic [2:0] STG_SPIN  = 3'd4;
    localparam logic [2:0] STG_DONE  = 3'd5;

    // Supervisor states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_DONE,
        S_FAULT
    } sup_state_e;

    // Latched fault codes.
    localparam logic [2:0] FLT_NONE   = 3'd0;
    localparam logic [2:0] FLT_NO_ACK = 3'd1;
    localparam logic [2:0] FLT_SEQ    = 3'd2;
    localparam logic [2:0] FLT_STALL  = 3'd3;
    localparam logic [2:0] FLT_DOOR   = 3'd4;

    // Successor of a stage, wrapping at 3 bits.
    function automatic logic [2:0] stage_next(input logic [2:0] s);
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/wm_stage_checker.sv
// Combinational legality check of the reported stage against the last accepted one.
// All outputs are suppressed while the door is open (door fault has priority) or
// while power is down (checks are frozen).
module wm_stage_checker
    import wm_pkg::*;
(
    input  logic [2:0] stage_i,
    input  logic [2:0] prev_stage_i,
    input  logic       door_closed_i,
    input  logic       supply_ok_i,
    output logic       seq_err_o,
    output logic       advance_o,
    output logic       is_done_o
);

    logic       active;
    logic [2:0] succ;

    assign active = door_closed_i & supply_ok_i;
    assign succ   = stage_next(prev_stage_i);

    // Classify the current stage relative to the last accepted stage.
    always_comb begin
        seq_err_o = active && (stage_i != prev_stage_i) && (stage_i != succ);
        advance_o = active && (stage_i == succ);
        is_done_o = active && (stage_i == STG_DONE);
    end

endmodule

// File: rtl/wm_supervisor.sv
// Front-panel supervisor: issues the start request, polices the stage sequence,
// drives the door lock and latches a fault code on any violation.
module wm_supervisor
    import wm_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT  = 4,
    parameter int unsigned STALL_LIMIT  = 16,
    parameter int unsigned UNLOCK_DELAY = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       door_closed,
    input  logic       supply_ok,
    input  logic       clear_fault,
    input  logic [2:0] stage,
    output logic       cycle,
    output logic       door_lock,
    output logic       busy,
    output logic       done_pulse,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [CNT_W-1:0] AckLast   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StallLast = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] UnlockEnd = CNT_W'(UNLOCK_DELAY);

    sup_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       code_q, code_d;
    logic             start_q;
    logic             start_rise;
    logic             seq_err, advance, is_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign start_rise = start_btn & ~start_q;

    wm_stage_checker u_checker (
        .stage_i       (stage),
        .prev_stage_i  (prev_q),
        .door_closed_i (door_closed),
        .supply_ok_i   (supply_ok),
        .seq_err_o     (seq_err),
        .advance_o     (advance),
        .is_done_o     (is_done)
    );

    // State, counter, stage history, fault code and start-button history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prev_q  <= STG_IDLE;
            code_q  <= FLT_NONE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            code_q  <= code_d;
            start_q <= start_btn;
        end
    end

    // Next-state logic; fault_code is only written on entry to S_FAULT so it never
    // gets overwritten while the fault is pending.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_rise && door_closed && supply_ok && stage == STG_IDLE) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                // Acknowledge wins over a simultaneous timeout.
                if (stage == STG_FILL) begin
                    state_d = S_RUN;
                    prev_d  = STG_FILL;
                    cnt_d   = '0;
                end else if (cnt_q == AckLast) begin
                    state_d = S_FAULT;
                    code_d  = FLT_NO_ACK;
                end else if (supply_ok) begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_RUN: begin
                if (!door_closed) begin
                    state_d = S_FAULT;
                    code_d  = FLT_DOOR;
                end else if (seq_err) begin
                    state_d = S_FAULT;
                    code_d  = FLT_SEQ;
                end else if (is_done) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else if (advance) begin
                    prev_d = stage;
                    cnt_d  = '0;
                end else if (supply_ok) begin
                    if (cnt_q == StallLast) begin
                        state_d = S_FAULT;
                        code_d  = FLT_STALL;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            S_DONE: begin
                if (cnt_q == UnlockEnd) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_FAULT: begin
                if (clear_fault && stage == STG_IDLE && door_closed) begin
                    state_d = S_IDLE;
                    code_d  = FLT_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        cycle      = (state_q == S_REQ);
        busy       = (state_q != S_IDLE);
        door_lock  = (state_q == S_REQ) || (state_q == S_RUN) ||
                     (state_q == S_DONE) || (state_q == S_FAULT);
        done_pulse = (state_q == S_DONE) && (cnt_q == '0);
        fault      = (state_q == S_FAULT);
        fault_code = code_q;
    end

endmodule

// File: tb/tb_wm_supervisor.sv
// Directed bench for wm_supervisor with immediate-assertion checks.
module tb_wm_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       door_closed;
    logic       supply_ok;
    logic       clear_fault;
    logic [2:0] stage;
    logic       cycle;
    logic       door_lock;
    logic       busy;
    logic       done_pulse;
    logic       fault;
    logic [2:0] fault_code;

    int n_assert = 0;
    int n_fail   = 0;

    wm_supervisor dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .door_closed (door_closed),
        .supply_ok   (supply_ok),
        .clear_fault (clear_fault),
        .stage       (stage),
        .cycle       (cycle),
        .door_lock   (door_lock),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    int cyc_cnt, done_cnt, fault_cnt, t_idx, t_done, t_unlock;

    initial begin
        rst = 1'b1; start_btn = 1'b0; door_closed = 1'b1; supply_ok = 1'b1;
        clear_fault = 1'b0; stage = 3'd0;
        tick(); tick();
        chk("rst_cycle", cycle, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lock", door_lock, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        rst = 1'b0;
        tick();

        // 1: full legal wash
        press_start();
        chk("t1_req_cycle", cycle, 1);
        chk("t1_req_lock", door_lock, 1);
        cyc_cnt = 1; done_cnt = 0; fault_cnt = 0; t_idx = 0; t_done = -1; t_unlock = -1;
        for (int s = 1; s <= 6; s++) begin
            stage = (s == 6) ? 3'd0 : 3'(s);
            for (int k = 0; k < 3; k++) begin
                tick();
                t_idx++;
                cyc_cnt  += int'(cycle);
                done_cnt += int'(done_pulse);
                fault_cnt += int'(fault);
                if (done_pulse && t_done < 0) t_done = t_idx;
                if (!door_lock && t_unlock < 0 && t_done >= 0) t_unlock = t_idx;
            end
        end
        chk("t1_cycle_count", cyc_cnt, 1);
        chk("t1_done_count", done_cnt, 1);
        chk("t1_fault_seen", fault_cnt, 0);
        chk("t1_unlock_delay", t_unlock - t_done, 3);
        chk("t1_end_busy", busy, 0);

        // 2: no acknowledge
        stage = 3'd0;
        press_start();
        cyc_cnt = int'(cycle);
        for (int k = 0; k < 5; k++) begin
            tick();
            cyc_cnt += int'(cycle);
        end
        chk("t2_cycle_count", cyc_cnt, 4);
        chk("t2_fault", fault, 1);
        chk("t2_code", fault_code, 1);
        chk("t2_lock", door_lock, 1);
        chk("t2_cycle", cycle, 0);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        chk("t2_clr_fault", fault, 0);
        chk("t2_clr_code", fault_code, 0);
        chk("t2_clr_busy", busy, 0);

        // 3: illegal jump 2 -> 4, fault code must not be overwritten
        press_start();
        stage = 3'd1; tick();
        stage = 3'd2; tick();
        chk("t3_pre_fault", fault, 0);
        stage = 3'd4; tick();
        chk("t3_code", fault_code, 2);
        door_closed = 1'b0; tick(); door_closed = 1'b1;
        chk("t3_no_overwrite", fault_code, 2);
        clear_fault = 1'b1; tick();
        chk("t3_clear_stage_nz", fault, 1);
        stage = 3'd0; tick(); clear_fault = 1'b0;
        chk("t3_clr_fault", fault, 0);
        chk("t3_clr_code", fault_code, 0);

        // 4a: WASH stall with power on
        press_start();
        stage = 3'd1; tick();
        stage = 3'd2; tick();
        fault_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            fault_cnt += int'(fault);
        end
        chk("t4a_no_early_fault", fault_cnt, 0);
        tick();
        chk("t4a_code", fault_code, 3);
        stage = 3'd0; clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        chk("t4a_clr", fault, 0);

        // 4b: stall counter frozen while unpowered
        press_start();
        stage = 3'd1; tick();
        stage = 3'd2; tick();
        fault_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            supply_ok = (k >= 8 && k < 18) ? 1'b0 : 1'b1;
            tick();
            fault_cnt += int'(fault);
        end
        supply_ok = 1'b1;
        chk("t4b_no_early_fault", fault_cnt, 0);
        tick();
        chk("t4b_code", fault_code, 3);
        stage = 3'd0; clear_fault = 1'b1; tick(); clear_fault = 1'b0;

        // 5: door opened during RINSE, then start with door open
        press_start();
        stage = 3'd1; tick();
        stage = 3'd2; tick();
        stage = 3'd3; tick();
        door_closed = 1'b0; tick();
        chk("t5_code", fault_code, 4);
        chk("t5_lock", door_lock, 1);
        stage = 3'd0; clear_fault = 1'b1; tick();
        chk("t5_clear_door_open", fault, 1);
        door_closed = 1'b1; tick(); clear_fault = 1'b0;
        chk("t5_clr", fault, 0);
        door_closed = 1'b0;
        press_start();
        chk("t5_open_cycle", cycle, 0);
        chk("t5_open_busy", busy, 0);
        door_closed = 1'b1;
        tick();

        // 6: reset mid-SPIN with start held through reset
        press_start();
        stage = 3'd1; tick();
        stage = 3'd2; tick();
        stage = 3'd3; tick();
        stage = 3'd4; tick();
        chk("t6_spin_busy", busy, 1);
        start_btn = 1'b1; rst = 1'b1; tick();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_lock", door_lock, 0);
        chk("t6_rst_cycle", cycle, 0);
        chk("t6_rst_fault", fault, 0);
        rst = 1'b0; tick();
        stage = 3'd0; tick(); tick(); tick();
        chk("t6_held_no_start", busy, 0);
        start_btn = 1'b0; tick();
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        chk("t6_repress_cycle", cycle, 1);

        // Acknowledge on the timeout cycle wins
        tick(); tick(); tick();
        stage = 3'd1; tick();
        chk("t7_ack_wins_fault", fault, 0);
        chk("t7_ack_wins_cycle", cycle, 0);
        chk("t7_ack_wins_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
